// File: rtl/cache_ctrl_pkg.sv
// cache_ctrl_pkg: shared widths and FSM state encoding for cache_lookup_ctrl.
// No ports; imported by cache_lookup_ctrl and sat_counter.
package cache_ctrl_pkg;

  localparam int KEY_W_DEF = 8;
  localparam int VAL_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    CHECK  = 3'd2,
    MEM    = 3'd3,
    FILL   = 3'd4,
    RESP   = 3'd5
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones, sync active-high reset.
// Ports: clk, reset, inc (count enable), count (current value).
module sat_counter
  import cache_ctrl_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && !(&r_count)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/cache_lookup_ctrl.sv
// cache_lookup_ctrl: one-at-a-time lookup front end for an 8-entry key/value
// cache; hits return the cached value, misses fetch from a backing store
// (mem_req/mem_ack), fill the cache via update, then respond.
// Ports: req_* request in, resp_* response out, find/key/match_found/value
// cache lookup, update* cache insert, mem_* backing store, hit_cnt/miss_cnt
// statistics (live only when CACHE_LOOKUP_STATS_EN is defined, else 0).
module cache_lookup_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF,
  parameter int VAL_W = VAL_W_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [KEY_W-1:0] req_key,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [VAL_W-1:0] resp_value,
  output logic             resp_hit,
  output logic             find,
  output logic [KEY_W-1:0] key,
  input  logic             match_found,
  input  logic [VAL_W-1:0] value,
  output logic             update,
  output logic [KEY_W-1:0] update_key,
  output logic [VAL_W-1:0] update_value,
  output logic             mem_req,
  output logic [KEY_W-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [VAL_W-1:0] mem_rdata,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  state_t           r_state;
  state_t           w_next;
  logic [KEY_W-1:0] r_key;
  logic [VAL_W-1:0] r_val;
  logic             r_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // r_val carries either the cache hit data or the refill data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_key <= '0;
      r_val <= '0;
      r_hit <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) r_key <= req_key;
        end
        CHECK: begin
          if (match_found) begin
            r_val <= value;
            r_hit <= 1'b1;
          end
        end
        MEM: begin
          if (mem_ack) r_val <= mem_rdata;
        end
        FILL: begin
          r_hit <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Data outputs are gated by state so nothing stale leaks onto idle buses.
  always_comb begin
    w_next       = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_value   = '0;
    resp_hit     = 1'b0;
    find         = 1'b0;
    key          = '0;
    update       = 1'b0;
    update_key   = '0;
    update_value = '0;
    mem_req      = 1'b0;
    mem_addr     = '0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = LOOKUP;
      end
      LOOKUP: begin
        find   = 1'b1;
        key    = r_key;
        w_next = CHECK;
      end
      CHECK: begin
        w_next = match_found ? RESP : MEM;
      end
      MEM: begin
        mem_req  = 1'b1;
        mem_addr = r_key;
        if (mem_ack) w_next = FILL;
      end
      FILL: begin
        update       = 1'b1;
        update_key   = r_key;
        update_value = r_val;
        w_next       = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_value = r_val;
        resp_hit   = r_hit;
        if (resp_ready) w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

`ifdef CACHE_LOOKUP_STATS_EN
  logic w_hit_inc;
  logic w_miss_inc;

  assign w_hit_inc  = (r_state == CHECK) && match_found;
  assign w_miss_inc = (r_state == CHECK) && !match_found;

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_hit_inc),
    .count (hit_cnt)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_miss_inc),
    .count (miss_cnt)
  );
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: doc/cache_lookup_ctrl.md
Name: cache_lookup_ctrl

Overview:
- Initiator that sits in front of the 8-entry key/value cache and drives its find and update ports.
- Accepts one lookup request at a time and issues find to the cache.
- On hit, returns the cached value. On miss, fetches the value from a backing store over a req/ack handshake, writes it into the cache with update, then returns it.

Parameters:
- KEY_W, 8, key width; must match the cache key width.
- VAL_W, 8, value width; must match the cache value width.
- CNT_W, 16, width of the hit and miss statistics counters.

Ports:
- clk  in  1  clock; every flop is rising-edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  lookup request valid.
- req_ready  out  1  controller can accept a request (high only in IDLE).
- req_key  in  KEY_W  key to look up.
- resp_valid  out  1  response valid; held until resp_ready.
- resp_ready  in  1  consumer accepts the response.
- resp_value  out  VAL_W  looked-up value.
- resp_hit  out  1  1 = served from cache, 0 = filled from backing store.
- find  out  1  cache find strobe.
- key  out  KEY_W  cache find key.
- match_found  in  1  cache hit flag, registered by the cache one cycle after find.
- value  in  VAL_W  cache value, valid with match_found.
- update  out  1  cache insert strobe (one cycle).
- update_key  out  KEY_W  key to insert.
- update_value  out  VAL_W  value to insert.
- mem_req  out  1  backing-store read request; held until mem_ack.
- mem_addr  out  KEY_W  backing-store address (equals the key).
- mem_ack  in  1  backing-store data valid.
- mem_rdata  in  VAL_W  backing-store data.
- hit_cnt  out  CNT_W  hit counter (see Optional Feature).
- miss_cnt  out  CNT_W  miss counter (see Optional Feature).

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - All outputs are 0 except req_ready, which is 1.
  - Latched key, latched value, hit_cnt and miss_cnt are cleared.
  - Reset mid-operation abandons the transaction: mem_req drops in the cycle after reset is sampled, and no update or resp_valid is issued.
- States are IDLE, LOOKUP, CHECK, MEM, FILL, RESP.
- IDLE: req_ready=1. If req_valid, latch req_key and go to LOOKUP. Otherwise stay.
- LOOKUP: find=1 and key=latched key for exactly one cycle, then go to CHECK.
- CHECK: sample match_found and value (the cache's registered result from LOOKUP).
  - If match_found=1: latch value, set hit=1, go to RESP.
  - Else: go to MEM.
- MEM: mem_req=1 and mem_addr=latched key, held until mem_ack.
  - On mem_ack, latch mem_rdata, go to FILL, and mem_req deasserts the next cycle.
  - mem_ack in the first MEM cycle is legal.
  - mem_ack outside MEM is ignored.
- FILL: update=1, update_key=latched key, update_value=latched data for exactly one cycle. Set hit=0 and go to RESP.
- RESP: resp_valid=1, with resp_value and resp_hit stable. When resp_ready=1, go to IDLE in the next cycle.
- find and update are never both high. Neither is ever high outside LOOKUP or FILL.
- Latency, from the req_valid&&req_ready cycle T:
  - Hit: resp_valid rises at T+3.
  - Miss: resp_valid rises 2 cycles after the mem_ack cycle.
- A new request is accepted only in IDLE; req_valid is ignored otherwise.
- resp_ready is ignored outside RESP. resp_ready held high gives back-to-back requests with one IDLE cycle between them.

Optional Feature:
- Macro: CACHE_LOOKUP_STATS_EN.
- Defined:
  - hit_cnt increments on each CHECK cycle with match_found=1.
  - miss_cnt increments on each CHECK cycle with match_found=0.
  - Both saturate at all-ones and clear on reset.
- Undefined: no counter flops; hit_cnt and miss_cnt are tied to 0.

Decomposition:
- Package cache_ctrl_pkg holds KEY_W_DEF=8, VAL_W_DEF=8, and the state enum (IDLE, LOOKUP, CHECK, MEM, FILL, RESP) with 3-bit encoding.
- One sub-module, sat_counter (parameter W; ports clk, reset, inc, count), instantiated twice under the macro.

Test Plan:
- Reset the cache (key k holds k+50 for k=1..8) and controller; request key 3 -> find pulse with key=3 at T+1, resp_valid at T+3 with resp_value=53 and resp_hit=1; mem_req never asserted.
- Request key 0x20, memory acks after 4 cycles with mem_rdata=0xA5 -> mem_addr=0x20 held until ack, one update pulse with update_key=0x20 and update_value=0xA5, resp_value=0xA5, resp_hit=0.
- Repeat key 0x20 after the fill -> hit, resp_value=0xA5, resp_hit=1, no mem_req.
- Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_value stay stable; req_ready=0; a req_valid pulse during the stall is ignored.
- Assert reset for one cycle during MEM -> mem_req=0 the next cycle, no update and no resp; a later mem_ack is ignored; req_ready=1.
- With CACHE_LOOKUP_STATS_EN and CNT_W=2: 4 hits then 1 miss -> hit_cnt saturates at 3, miss_cnt=1. Without the macro, both read 0 throughout.
